snax_csr_manager: RTL and testbench

// - Consumes the simplified CSR request/response stream produced by the SNAX interface translator.
// - Holds accelerator configuration in NumRwCsr read-write registers and exposes NumRoCsr status words.
// - Launches the accelerator through a valid/ready config handshake.
// - Write locking: RW writes are locked while a launch is pending or the accelerator is busy.

---
 rtl/snax_csr_pkg.sv | 21 ++
 rtl/snax_csr_manager_if.sv | 22 ++
 rtl/snax_csr_rsp_buffer.sv | 45 ++++
 rtl/snax_csr_manager.sv | 119 +++++++++++
 tb/tb_snax_csr_manager.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/snax_csr_pkg.sv
// Shared types for the SNAX CSR manager: request/response payloads and launch FSM states.
package snax_csr_pkg;

    localparam int unsigned CsrWidth = 32;

    typedef struct packed {
        logic [CsrWidth-1:0] data;
        logic [CsrWidth-1:0] addr;
        logic                write;
    } csr_req_t;

    typedef struct packed {
        logic [CsrWidth-1:0] data;
    } csr_rsp_t;

    typedef enum logic {
        IDLE,
        PEND
    } launch_state_e;

endpackage

// File: rtl/snax_csr_manager_if.sv
// CSR request/response stream between the interface translator (master) and the CSR manager (slave).
interface snax_csr_manager_if;
    import snax_csr_pkg::*;

    csr_req_t req;
    logic     req_valid;
    logic     req_ready;
    csr_rsp_t rsp;
    logic     rsp_valid;
    logic     rsp_ready;

    modport master (
        output req, req_valid, rsp_ready,
        input  req_ready, rsp, rsp_valid
    );

    modport slave (
        input  req, req_valid, rsp_ready,
        output req_ready, rsp, rsp_valid
    );

endinterface

// File: rtl/snax_csr_rsp_buffer.sv
// One-entry response register: loads read data on accept, holds it until the consumer takes it.
module snax_csr_rsp_buffer
    import snax_csr_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     in_valid_i,
    input  csr_rsp_t in_rsp_i,
    output logic     in_ready_o,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output csr_rsp_t out_rsp_o
);

    logic     valid_q, valid_d;
    csr_rsp_t rsp_q, rsp_d;

    // Drain and refill may happen in the same cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_rsp_o   = rsp_q;

    always_comb begin
        valid_d = valid_q;
        rsp_d   = rsp_q;
        if (out_ready_i) begin
            valid_d = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            rsp_d   = in_rsp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: rtl/snax_csr_manager.sv
// CSR manager: RW config register file, RO status readback, write lock and accelerator launch handshake.
module snax_csr_manager
    import snax_csr_pkg::*;
#(
    parameter int unsigned NumRwCsr  = 8,
    parameter int unsigned NumRoCsr  = 2,
    parameter int unsigned StartAddr = NumRwCsr + NumRoCsr
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    snax_csr_manager_if.slave            csr_if,
    output logic [CsrWidth*NumRwCsr-1:0] csr_reg_set_o,
    output logic                         csr_reg_set_valid_o,
    input  logic                         csr_reg_set_ready_i,
    input  logic [CsrWidth*NumRoCsr-1:0] csr_reg_ro_set_i,
    input  logic                         acc_busy_i
);

    logic [CsrWidth-1:0] regs_q [NumRwCsr];
    logic [CsrWidth-1:0] regs_d [NumRwCsr];
    launch_state_e       state_q, state_d;

    logic     set_valid, lock;
    logic     is_rw, is_ro, is_start;
    logic     buf_in_ready, rd_acc, wr_acc;
    csr_rsp_t rd_rsp;

    assign set_valid = (state_q == PEND);
    assign lock      = set_valid || acc_busy_i;

    assign is_rw    = csr_if.req.addr < CsrWidth'(NumRwCsr);
    assign is_start = !is_rw && (csr_if.req.addr == CsrWidth'(StartAddr));
    assign is_ro    = !is_rw && !is_start && (csr_if.req.addr < CsrWidth'(NumRwCsr + NumRoCsr));

    // Writes that change config or launch stall under lock; reads only wait on the response slot.
    always_comb begin
        if (csr_if.req.write) begin
            csr_if.req_ready = !((is_rw || is_start) && lock);
        end else begin
            csr_if.req_ready = buf_in_ready;
        end
    end

    assign wr_acc = csr_if.req_valid && csr_if.req.write && csr_if.req_ready;
    assign rd_acc = csr_if.req_valid && !csr_if.req.write && buf_in_ready;

    // Read data mux, captured by the response buffer in the accept cycle.
    always_comb begin
        rd_rsp.data = '0;
        if (is_rw) begin
            for (int unsigned k = 0; k < NumRwCsr; k++) begin
                if (csr_if.req.addr == CsrWidth'(k)) begin
                    rd_rsp.data = regs_q[k];
                end
            end
        end else if (is_start) begin
            rd_rsp.data = {30'b0, acc_busy_i, set_valid};
        end else if (is_ro) begin
            for (int unsigned k = 0; k < NumRoCsr; k++) begin
                if (csr_if.req.addr == CsrWidth'(NumRwCsr + k)) begin
                    rd_rsp.data = csr_reg_ro_set_i[k*CsrWidth +: CsrWidth];
                end
            end
        end
    end

    snax_csr_rsp_buffer u_rsp_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (rd_acc),
        .in_rsp_i    (rd_rsp),
        .in_ready_o  (buf_in_ready),
        .out_valid_o (csr_if.rsp_valid),
        .out_ready_i (csr_if.rsp_ready),
        .out_rsp_o   (csr_if.rsp)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_acc && is_rw) begin
            for (int unsigned k = 0; k < NumRwCsr; k++) begin
                if (csr_if.req.addr == CsrWidth'(k)) begin
                    regs_d[k] = csr_if.req.data;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NumRwCsr; k++) begin
            csr_reg_set_o[k*CsrWidth +: CsrWidth] = regs_q[k];
        end
    end

    // Launch FSM: PEND holds the launch request until the accelerator takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (wr_acc && is_start) state_d = PEND;
            PEND: if (csr_reg_set_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign csr_reg_set_valid_o = set_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < NumRwCsr; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_snax_csr_manager.sv
// Directed bench for snax_csr_manager: writes, reads, launch handshake, write lock, backpressure and reset.
module tb_snax_csr_manager;
    import snax_csr_pkg::*;

    localparam int unsigned NRW   = 8;
    localparam int unsigned NRO   = 2;
    localparam int unsigned START = NRW + NRO;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [32*NRW-1:0]     reg_set;
    logic                  set_valid;
    logic                  set_ready;
    logic [32*NRO-1:0]     ro_set;
    logic                  busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_regs [NRW];

    snax_csr_manager_if bus ();

    snax_csr_manager #(
        .NumRwCsr  (NRW),
        .NumRoCsr  (NRO),
        .StartAddr (START)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_if              (bus),
        .csr_reg_set_o       (reg_set),
        .csr_reg_set_valid_o (set_valid),
        .csr_reg_set_ready_i (set_ready),
        .csr_reg_ro_set_i    (ro_set),
        .acc_busy_i          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [32*NRW-1:0] exp;
        for (int k = 0; k < NRW; k++) exp[k*32 +: 32] = exp_regs[k];
        n_assert++;
        assert (reg_set === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, reg_set, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = v;
        bus.req.write  = w;
        bus.req.addr   = a;
        bus.req.data   = d;
    endtask

    initial begin
        rst = 1'b1;
        set_ready = 1'b0;
        ro_set = '0;
        busy = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < NRW; k++) exp_regs[k] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp.data, 32'h0);
        check("rst_set_valid", 32'(set_valid), 32'd0);
        check_regs("rst_regs");

        // Write reg 3 and reg 0, then read reg 3
        @(negedge clk); rst = 1'b0; drive(1'b1, 1'b1, 32'd3, 32'hDEADBEEF); #1;
        check("wr3_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b1, 32'd0, 32'h000000F0); #1;
        check("wr0_ready", 32'(bus.req_ready), 32'd1);
        check("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
        exp_regs[3] = 32'hDEADBEEF;
        check_regs("wr3_regs");
        @(negedge clk); drive(1'b1, 1'b0, 32'd3, 32'h0); #1;
        check("rd3_ready", 32'(bus.req_ready), 32'd1);
        check("wr0_no_rsp", 32'(bus.rsp_valid), 32'd0);
        exp_regs[0] = 32'h000000F0;
        check_regs("wr0_regs");
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("rd3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd3_rsp_data", bus.rsp.data, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("rd3_drained", 32'(bus.rsp_valid), 32'd0);

        // Launch with accelerator not ready; RW write stalls meanwhile
        @(negedge clk); drive(1'b1, 1'b1, START, 32'h0); #1;
        check("start_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); drive(1'b1, 1'b1, 32'd1, 32'h00001111); #1;
            check("pend_set_valid", 32'(set_valid), 32'd1);
            check("pend_wr_stall", 32'(bus.req_ready), 32'd0);
            check_regs("pend_regs_stable");
            if (i == 4) set_ready = 1'b1;
        end
        @(negedge clk); set_ready = 1'b0; #1;
        check("launch_done", 32'(set_valid), 32'd0);
        check("post_launch_wr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp_regs[1] = 32'h00001111;
        check_regs("post_launch_regs");

        // Busy accelerator: RO read and StartAddr read proceed, RW write stalls
        @(negedge clk); busy = 1'b1; ro_set[31:0] = 32'h12345678; drive(1'b1, 1'b0, 32'd8, 32'h0); #1;
        check("ro_rd_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b0, START, 32'h0); #1;
        check("ro_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("ro_rsp_data", bus.rsp.data, 32'h12345678);
        check("status_rd_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b1, 32'd0, 32'hA5A5A5A5); #1;
        check("status_rsp_data", bus.rsp.data, 32'h00000002);
        check("busy_wr_stall", 32'(bus.req_ready), 32'd0);
        repeat (2) begin
            @(negedge clk); #1;
            check("busy_wr_stall_hold", 32'(bus.req_ready), 32'd0);
            check("busy_reg0_old", reg_set[31:0], 32'h000000F0);
        end
        @(negedge clk); busy = 1'b0; #1;
        check("unbusy_wr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        exp_regs[0] = 32'hA5A5A5A5;
        check_regs("unbusy_regs");

        // Response backpressure: second read waits, then drains and refills together
        @(negedge clk); bus.rsp_ready = 1'b0; drive(1'b1, 1'b0, 32'd3, 32'h0); #1;
        check("bp_rd1_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b0, 32'd0, 32'h0); #1;
        check("bp_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rsp1_data", bus.rsp.data, 32'hDEADBEEF);
        check("bp_rd2_stall", 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        check("bp_rsp1_hold", bus.rsp.data, 32'hDEADBEEF);
        check("bp_rd2_stall_hold", 32'(bus.req_ready), 32'd0);
        @(negedge clk); bus.rsp_ready = 1'b1; #1;
        check("bp_rd2_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check("bp_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rsp2_data", bus.rsp.data, 32'hA5A5A5A5);
        @(negedge clk); #1;
        check("bp_drained", 32'(bus.rsp_valid), 32'd0);

        // Out-of-range address
        @(negedge clk); drive(1'b1, 1'b0, 32'h40, 32'h0); #1;
        check("oor_rd_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF); #1;
        check("oor_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("oor_rsp_data", bus.rsp.data, 32'h0);
        check("oor_wr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); busy = 1'b1; #1;
        check("oor_wr_ready_locked", 32'(bus.req_ready), 32'd1);
        @(negedge clk); busy = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        check_regs("oor_regs");
        check("oor_set_valid", 32'(set_valid), 32'd0);

        // Reset while launch pending and response outstanding
        @(negedge clk); drive(1'b1, 1'b1, START, 32'h0); #1;
        check("rst_start_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); bus.rsp_ready = 1'b0; drive(1'b1, 1'b0, 32'd3, 32'h0); #1;
        check("rst_pre_set_valid", 32'(set_valid), 32'd1);
        check("rst_pre_rd_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1; #1;
        check("rst_pre_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rst_pre_rsp_data", bus.rsp.data, 32'hDEADBEEF);
        @(negedge clk); rst = 1'b0; #1;
        for (int k = 0; k < NRW; k++) exp_regs[k] = 32'h0;
        check("rst_set_valid_cleared", 32'(set_valid), 32'd0);
        check("rst_rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data_cleared", bus.rsp.data, 32'h0);
        check_regs("rst_regs_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
